// File: rtl/mio_arbiter_if.sv
// rtl/mio_arbiter_if.sv - CPU, device and memory port signals of the memory/IO arbiter
interface mio_arbiter_if;
  logic        CPU_MIO;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        MIO_ready;
  logic        dev_req;
  logic [31:0] dev_addr;
  logic [31:0] dev_rdata;
  logic        dev_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  grant;

  modport slave (
    input  CPU_MIO, cpu_we, cpu_addr, cpu_wdata, dev_req, dev_addr, mem_rdata,
    output cpu_rdata, MIO_ready, dev_rdata, dev_ack, mem_en, mem_we, mem_addr, mem_wdata, grant
  );

  modport master (
    output CPU_MIO, cpu_we, cpu_addr, cpu_wdata, dev_req, dev_addr, mem_rdata,
    input  cpu_rdata, MIO_ready, dev_rdata, dev_ack, mem_en, mem_we, mem_addr, mem_wdata, grant
  );
endinterface

// File: rtl/mio_arbiter.sv
// rtl/mio_arbiter.sv - two-requester memory/IO port arbiter; MIO_ARB_STARVE_EN enables device anti-starvation
module mio_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  mio_arbiter_if.slave  bus
);

  localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_dev_q, owner_dev_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   dev_rdata_q, dev_rdata_d;
  logic          mio_ready_q, mio_ready_d;
  logic          dev_ack_q, dev_ack_d;
  logic          dev_win;
  logic          cpu_win;

`ifdef MIO_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] streak_q, streak_d;

  // The device wins a tie once the CPU has taken STARVE_MAX grants in a row past it
  always_comb begin
    dev_win = bus.dev_req && (!bus.CPU_MIO || (streak_q == SW'(STARVE_MAX)));
    cpu_win = bus.CPU_MIO && !dev_win;
  end

  // Starvation streak: counts CPU grants taken while the device was waiting
  always_comb begin
    streak_d = streak_q;
    if (state_q == ST_IDLE) begin
      if (!bus.dev_req || dev_win) begin
        streak_d = '0;
      end else if (cpu_win && (streak_q != SW'(STARVE_MAX))) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  // Streak register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) streak_q <= '0;
    else        streak_q <= streak_d;
  end
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX > 0);

  // Fixed priority: the device only gets the port when the CPU is not asking
  always_comb begin
    dev_win = bus.dev_req && !bus.CPU_MIO;
    cpu_win = bus.CPU_MIO;
  end
`endif

  // Next-state and datapath: arbitrate in IDLE, count down ACC, strobe the owner in RESP
  always_comb begin
    state_d     = state_q;
    owner_dev_d = owner_dev_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    cpu_rdata_d = cpu_rdata_q;
    dev_rdata_d = dev_rdata_q;
    mio_ready_d = 1'b0;
    dev_ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_win) begin
          owner_dev_d = 1'b0;
          we_d        = bus.cpu_we;
          addr_d      = bus.cpu_addr;
          wdata_d     = bus.cpu_wdata;
          wait_d      = WW'(MEM_LAT - 1);
          state_d     = ST_ACC;
        end else if (dev_win) begin
          owner_dev_d = 1'b1;
          we_d        = 1'b0;
          addr_d      = bus.dev_addr;
          wdata_d     = '0;
          wait_d      = WW'(MEM_LAT - 1);
          state_d     = ST_ACC;
        end
      end
      ST_ACC: begin
        if (wait_q == '0) begin
          if (owner_dev_q) begin
            dev_rdata_d = bus.mem_rdata;
            dev_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = bus.mem_rdata;
            mio_ready_d = 1'b1;
          end
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All arbiter state; reset aborts any access in flight without a strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_dev_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      cpu_rdata_q <= '0;
      dev_rdata_q <= '0;
      mio_ready_q <= 1'b0;
      dev_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dev_q <= owner_dev_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      dev_rdata_q <= dev_rdata_d;
      mio_ready_q <= mio_ready_d;
      dev_ack_q   <= dev_ack_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.mem_en    = (state_q == ST_ACC);
    bus.mem_we    = we_q && (state_q == ST_ACC);
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.cpu_rdata = cpu_rdata_q;
    bus.dev_rdata = dev_rdata_q;
    bus.MIO_ready = mio_ready_q;
    bus.dev_ack   = dev_ack_q;
    if (state_q == ST_IDLE) bus.grant = 2'b00;
    else                    bus.grant = owner_dev_q ? 2'b10 : 2'b01;
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// tb/tb_mio_arbiter.sv - randomized transaction-timeline check of mio_arbiter
module tb_mio_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
`ifdef MIO_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mio_arbiter_if bus();

  mio_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_t counts cycles since grant (0 idle, 1..MEM_LAT access, MEM_LAT+1 response)
  int          m_t;
  int          m_streak;
  bit          m_dev;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_cpu_rdata;
  logic [31:0] m_dev_rdata;
  int          n_dev_grants;
  int          n_cpu_grants;
  bit          hold_mode;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_streak = 0; m_dev = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_cpu_rdata = '0; m_dev_rdata = '0;
  endtask

  // Advance the model across the coming rising edge using the inputs now driven
  task automatic model_step();
    bit dw, cw;
    if (m_t == 0) begin
      dw = bus.dev_req && (!bus.CPU_MIO || (STARVE_EN && m_streak == STARVE_MAX));
      cw = bus.CPU_MIO && !dw;
      if (!bus.dev_req || dw) m_streak = 0;
      else if (cw && m_streak < STARVE_MAX) m_streak++;
      if (cw || dw) begin
        m_t   = 1;
        m_dev = dw;
        m_we  = dw ? 1'b0 : bus.cpu_we;
        m_addr  = dw ? bus.dev_addr : bus.cpu_addr;
        m_wdata = bus.cpu_wdata;
        if (dw) n_dev_grants++; else n_cpu_grants++;
      end
    end else begin
      if (m_t == MEM_LAT) begin
        if (m_dev) m_dev_rdata = bus.mem_rdata;
        else       m_cpu_rdata = bus.mem_rdata;
      end
      m_t = (m_t == MEM_LAT + 1) ? 0 : m_t + 1;
    end
  endtask

  task automatic check_outputs();
    bit acc, resp;
    acc  = (m_t >= 1 && m_t <= MEM_LAT);
    resp = (m_t == MEM_LAT + 1);
    check_eq("mem_en", bus.mem_en, acc);
    check_eq("MIO_ready", bus.MIO_ready, resp && !m_dev);
    check_eq("dev_ack", bus.dev_ack, resp && m_dev);
    check_eq("cpu_rdata", bus.cpu_rdata, m_cpu_rdata);
    check_eq("dev_rdata", bus.dev_rdata, m_dev_rdata);
    if (!resp) check_eq("grant", bus.grant, acc ? (m_dev ? 2'b10 : 2'b01) : 2'b00);
    if (acc) begin
      check_eq("mem_we", bus.mem_we, m_we);
      check_eq("mem_addr", bus.mem_addr, m_addr);
      if (m_we) check_eq("mem_wdata", bus.mem_wdata, m_wdata);
    end
  endtask

  // Requester agents: hold until strobe, then drop or keep (a held request is a new access)
  task automatic drive_inputs();
    if (bus.MIO_ready) begin
      if (hold_mode || $urandom_range(0, 3) == 0) begin
        bus.cpu_we = 1'($urandom); bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
      end else begin
        bus.CPU_MIO = 1'b0;
      end
    end else if (!bus.CPU_MIO && (hold_mode || $urandom_range(0, 3) == 0)) begin
      bus.CPU_MIO = 1'b1;
      bus.cpu_we = 1'($urandom); bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
    end
    if (bus.dev_ack) begin
      if (hold_mode || $urandom_range(0, 3) == 0) bus.dev_addr = $urandom;
      else bus.dev_req = 1'b0;
    end else if (!bus.dev_req && (hold_mode || $urandom_range(0, 2) == 0)) begin
      bus.dev_req = 1'b1;
      bus.dev_addr = $urandom;
    end
    bus.mem_rdata = $urandom;
  endtask

  task automatic do_cycle();
    @(negedge clk);
    check_outputs();
    drive_inputs();
    model_step();
  endtask

  initial begin
    int guard;
    hold_mode = 1'b0;
    n_dev_grants = 0; n_cpu_grants = 0;
    bus.CPU_MIO = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10; bus.cpu_wdata = '0;
    bus.dev_req = 1'b1; bus.dev_addr = 32'h400; bus.mem_rdata = 32'hDEADBEEF;
    model_reset();

    // Reset held with both requests high
    repeat (3) @(negedge clk);
    check_outputs();
    check_eq("rst_mem_we", bus.mem_we, 1'b0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'h0);
    bus.dev_req = 1'b0;
    reset = 1'b1;
    model_step();

    // Random traffic
    repeat (1500) do_cycle();

    // Both requesters held continuously
    hold_mode = 1'b1;
    n_dev_grants = 0; n_cpu_grants = 0;
    repeat (300) do_cycle();
    if (STARVE_EN) check_eq("starve_dev_grants", (n_dev_grants > 0), 1'b1);
    else           check_eq("fixed_dev_grants", n_dev_grants, 0);
    hold_mode = 1'b0;

    // Reset in the first access cycle: mem_en must drop without a clock edge
    guard = 0;
    bus.dev_req = 1'b0;
    do begin
      do_cycle();
      guard++;
    end while (!(m_t == 1 && !m_dev) && guard < 200);
    check_eq("midrst_reach_acc", (guard < 200), 1'b1);
    @(posedge clk);
    #2;
    check_eq("midrst_mem_en_before", bus.mem_en, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("midrst_mem_en", bus.mem_en, 1'b0);
    check_eq("midrst_grant", bus.grant, 2'b00);
    @(negedge clk);
    check_eq("midrst_ready", bus.MIO_ready, 1'b0);
    check_eq("midrst_ack", bus.dev_ack, 1'b0);
    model_reset();
    reset = 1'b1;
    model_step();
    check_eq("midrst_reserve", m_t, 1);

    repeat (600) do_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mio_arbiter.md
# mio_arbiter

- Sequences and shares the single memory/IO port between two requesters:
  - the multi-cycle CPU control path, which asserts `CPU_MIO` and waits on `MIO_ready`;
  - a read-only device requester, such as the display scan-out or a DMA reader.
- Grants one access at a time, drives the memory port for a fixed access latency, returns read data to the owner and pulses the owner's completion strobe.
- Sits between the CPU datapath/controller and the RAM/peripheral decoder.

## Interface
- `MEM_LAT`, 2: memory access cycles per transaction; must be ≥1.
- `STARVE_MAX`, 4: maximum number of consecutive CPU grants while the device is waiting; must be ≥1.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-low; 0 resets the block.
- `CPU_MIO`  in  1  CPU access request; held until `MIO_ready`.
- `cpu_we`  in  1  1 = write (`MemWrite`), 0 = read.
- `cpu_addr`  in  32  CPU address.
- `cpu_wdata`  in  32  CPU write data.
- `cpu_rdata`  out  32  CPU read data; valid when `MIO_ready`=1, then held.
- `MIO_ready`  out  1  one-cycle CPU completion pulse.
- `dev_req`  in  1  device read request; held until `dev_ack`.
- `dev_addr`  in  32  device address.
- `dev_rdata`  out  32  device read data; valid when `dev_ack`=1, then held.
- `dev_ack`  out  1  one-cycle device completion pulse.
- `mem_en`  out  1  memory port enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; valid during the last access cycle.
- `grant`  out  2  debug: 00 none, 01 CPU, 10 device.

## Operation
**State machine:** IDLE → ACC → RESP → IDLE.

**IDLE**
- `mem_en`=0 and `grant`=00.
- Requests are sampled here. With no request, stay in IDLE.
- Arbitration:
  - Only one requester active: that requester wins.
  - Both active: CPU wins unless `streak`==`STARVE_MAX`, in which case the device wins.
- On a grant:
  - latch owner, address, `we` (forced 0 for the device) and wdata into internal registers;
  - load `wait_cnt`=`MEM_LAT`-1;
  - go to ACC.

**ACC**
- `mem_en`=1. `mem_we`/`mem_addr`/`mem_wdata` come from the latched registers and are stable for the whole of ACC.
- `grant` shows the owner.
- `wait_cnt` decrements each cycle. When `wait_cnt`==0:
  - capture `mem_rdata` into the owner's rdata register (captured for writes too; CPU software ignores it);
  - go to RESP.

**RESP**
- `mem_en`=0.
- Pulse the owner's `MIO_ready` or `dev_ack` for exactly one cycle.
- Go to IDLE.
- The owner must deassert its request before the next rising edge. If the request is still high in IDLE, it is treated as a new access.

**Starvation counter `streak`**
- Width is clog2(`STARVE_MAX`+1); it saturates at `STARVE_MAX`.
- On a CPU grant with `dev_req`=1: increment.
- On a device grant: clear to 0.
- In IDLE with `dev_req`=0: clear to 0.

**Other rules**
- The rdata registers update only on their owner's capture. The non-owner's rdata and strobe are untouched.
- Requests arriving during ACC or RESP are not seen until the next IDLE. No request queueing.

## Timing
- **Reset (`reset`=0, asynchronous):**
  - state=IDLE;
  - `mem_en`, `mem_we`, `MIO_ready`, `dev_ack` = 0;
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `dev_rdata` = 0;
  - `grant`=00, `streak`=0, `wait_cnt`=0.
  - Reset during ACC aborts the access immediately (`mem_en` drops asynchronously), and no strobe is issued.
- **Latency:** a request sampled high at edge E gives:
  - ACC during cycles E+1 … E+`MEM_LAT`;
  - strobe high in cycle E+`MEM_LAT`+1.
  - Total: `MEM_LAT`+2 cycles from sample to IDLE re-entry.
- **Throughput:** back-to-back accesses use one transaction every `MEM_LAT`+2 cycles; IDLE lasts ≥1 cycle between transactions.
- **Output timing:** all outputs are registered or decoded from registered state; there are no combinational input-to-output paths.

## Configuration
- `MIO_ARB_STARVE_EN` defined:
  - the `streak` counter and the device-wins-at-`STARVE_MAX` rule are compiled in, as described above.
- `MIO_ARB_STARVE_EN` undefined:
  - no `streak` register;
  - fixed priority: the CPU always wins simultaneous requests, so the device waits until an IDLE cycle with `CPU_MIO`=0;
  - `STARVE_MAX` is ignored.

## Test plan
1. **Reset:** hold `reset`=0 with both requests high → all outputs 0 and `grant`=00. Release; with `MEM_LAT`=2, `CPU_MIO` read of addr 0x10 and `mem_rdata`=0xDEADBEEF → `mem_en` high for 2 cycles, `MIO_ready` pulses in cycle 3 after sampling, `cpu_rdata`=0xDEADBEEF.
2. **CPU write:** `cpu_we`=1, addr 0x20, wdata 0x12345678 → `mem_we`=1 with stable addr/data for both ACC cycles, one `MIO_ready` pulse, `dev_ack` stays 0.
3. **Simultaneous requests:** both requests held continuously, `STARVE_MAX`=4, macro defined → grant sequence CPU, CPU, CPU, CPU, DEV, CPU…. Without the macro → CPU every time, `dev_ack` never pulses.
4. **Device only:** `dev_req` with addr 0x400, `mem_rdata`=0xA5A5A5A5 → `dev_rdata`=0xA5A5A5A5, `dev_ack` one cycle, `mem_we`=0, `cpu_rdata` unchanged.
5. **Reset mid-access:** assert reset in the 1st ACC cycle → `mem_en` drops with no clock edge, no strobe. After release, a pending `CPU_MIO` is re-served from IDLE.
6. **Held request:** keep `CPU_MIO` high after `MIO_ready` → a second full transaction starts after exactly one IDLE cycle.
